rvfi_retire_serializer: RTL and testbench



---
 rtl/rvfi_retire_serializer_pkg.sv | 19 +
 rtl/rvfi_retire_serializer_if.sv | 25 ++
 rtl/rvfi_retire_serializer_compactor.sv | 47 ++++
 rtl/rvfi_retire_serializer.sv | 86 ++++++++
 tb/tb_rvfi_retire_serializer.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/rvfi_retire_serializer_pkg.sv
// Shared types for the RVFI retirement serializer.
// Entry layout and lane popcount helper.
package rvfi_ser_pkg;
    localparam int ORDER_W = 64;
    localparam int REC_W   = 256;

    typedef struct packed {
        logic [ORDER_W-1:0] order;
        logic [REC_W-1:0]   rec;
    } rvfi_ser_entry_t;

    function automatic logic [2:0] popcount_nret(input logic [3:0] v);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < 4; i++)
            n = n + {2'b00, v[i]};
        return n;
    endfunction
endpackage

// File: rtl/rvfi_retire_serializer_if.sv
// Retirement input lanes and serialized output handshake.
// master drives retirements and ready; slave is the serializer.
interface rvfi_retire_serializer_if #(
    parameter int NRET = 2
);
    import rvfi_ser_pkg::*;

    logic [NRET-1:0]         in_valid_i;
    logic [NRET*ORDER_W-1:0] in_order_i;
    logic [NRET*REC_W-1:0]   in_rec_i;
    logic                    out_valid_o;
    logic                    out_ready_i;
    logic [ORDER_W-1:0]      out_order_o;
    logic [REC_W-1:0]        out_rec_o;

    modport master (
        output in_valid_i, in_order_i, in_rec_i, out_ready_i,
        input  out_valid_o, out_order_o, out_rec_o
    );

    modport slave (
        input  in_valid_i, in_order_i, in_rec_i, out_ready_i,
        output out_valid_o, out_order_o, out_rec_o
    );
endinterface

// File: rtl/rvfi_retire_serializer_compactor.sv
// Packs valid retirement lanes in ascending lane order and
// checks order continuity along the packed sequence.
module rvfi_lane_compactor
    import rvfi_ser_pkg::*;
#(
    parameter int NRET = 2
) (
    input  logic [NRET-1:0]         valid,
    input  logic [NRET*ORDER_W-1:0] order,
    input  logic [NRET*REC_W-1:0]   rec,
    input  logic [ORDER_W-1:0]      exp_order,
    input  logic                    exp_valid,
    output rvfi_ser_entry_t         entries [NRET],
    output logic [2:0]              nvalid,
    output logic [NRET-1:0]         mismatch,
    output logic [ORDER_W-1:0]      nxt_order,
    output logic                    nxt_valid
);
    localparam int IW = (NRET > 1) ? $clog2(NRET) : 1;

    assign nvalid = popcount_nret(4'(valid));

    always_comb begin : pack
        logic [ORDER_W-1:0] e;
        logic               ev;
        int                 k;
        for (int i = 0; i < NRET; i++)
            entries[i] = '0;
        mismatch = '0;
        e  = exp_order;
        ev = exp_valid;
        k  = 0;
        for (int l = 0; l < NRET; l++) begin
            if (valid[l]) begin
                entries[k[IW-1:0]].order = order[l*ORDER_W +: ORDER_W];
                entries[k[IW-1:0]].rec   = rec[l*REC_W +: REC_W];
                // each packed entry is checked against its predecessor
                mismatch[k[IW-1:0]] = ev && (order[l*ORDER_W +: ORDER_W] != e);
                e  = order[l*ORDER_W +: ORDER_W] + ORDER_W'(1);
                ev = 1'b1;
                k  = k + 1;
            end
        end
        nxt_order = e;
        nxt_valid = ev;
    end
endmodule

// File: rtl/rvfi_retire_serializer.sv
// Buffers up to NRET retirements per cycle and replays them one
// per handshake in program order, flagging overflow and order gaps.
module rvfi_retire_serializer
    import rvfi_ser_pkg::*;
#(
    parameter int NRET  = 2,
    parameter int DEPTH = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    rvfi_retire_serializer_if.slave bus,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   overflow_o,
    output logic                   order_err_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    rvfi_ser_entry_t    mem [DEPTH];
    rvfi_ser_entry_t    head;
    rvfi_ser_entry_t    ent [NRET];
    logic [PW-1:0]      wptr, rptr;
    logic [ORDER_W-1:0] exp_order, nxt_order;
    logic               exp_valid, nxt_valid;
    logic [2:0]         nvalid;
    logic [NRET-1:0]    mism;
    logic [CW:0]        need;
    logic               pop, accept, wr;

    rvfi_lane_compactor #(.NRET(NRET)) u_compact (
        .valid     (bus.in_valid_i),
        .order     (bus.in_order_i),
        .rec       (bus.in_rec_i),
        .exp_order (exp_order),
        .exp_valid (exp_valid),
        .entries   (ent),
        .nvalid    (nvalid),
        .mismatch  (mism),
        .nxt_order (nxt_order),
        .nxt_valid (nxt_valid)
    );

    assign bus.out_valid_o = (count_o != '0);
    assign head            = bus.out_valid_o ? mem[rptr] : '0;
    assign bus.out_order_o = head.order;
    assign bus.out_rec_o   = head.rec;

    // same-cycle pop frees room for the same-cycle write
    assign pop    = bus.out_valid_o && bus.out_ready_i;
    assign need   = {1'b0, count_o} - (CW+1)'(pop) + (CW+1)'(nvalid);
    assign accept = (need <= (CW+1)'(DEPTH));
    assign wr     = accept && (nvalid != '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_o     <= '0;
            wptr        <= '0;
            rptr        <= '0;
            exp_order   <= '0;
            exp_valid   <= 1'b0;
            overflow_o  <= 1'b0;
            order_err_o <= 1'b0;
        end else begin
            if (pop)
                rptr <= rptr + PW'(1);
            if (wr) begin
                wptr      <= wptr + PW'(nvalid);
                exp_order <= nxt_order;
                exp_valid <= nxt_valid;
            end
            if (wr && (|mism))
                order_err_o <= 1'b1;
            if (!accept)
                overflow_o <= 1'b1;
            count_o <= accept ? need[CW-1:0] : count_o - CW'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && wr) begin
            for (int l = 0; l < NRET; l++)
                if (l < int'(nvalid))
                    mem[wptr + PW'(l)] <= ent[l];
        end
    end
endmodule

// File: tb/tb_rvfi_retire_serializer.sv
// Randomized bench for rvfi_retire_serializer against a queue model.
module tb_rvfi_retire_serializer;
    import rvfi_ser_pkg::*;

    localparam int NRET  = 2;
    localparam int DEPTH = 8;

    typedef struct {
        logic [63:0]  o;
        logic [255:0] r;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] count;
    logic       ovf, err;

    rvfi_retire_serializer_if #(.NRET(NRET)) bus ();

    rvfi_retire_serializer #(.NRET(NRET), .DEPTH(DEPTH)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .bus         (bus),
        .count_o     (count),
        .overflow_o  (ovf),
        .order_err_o (err)
    );

    always #5 clk = ~clk;

    ent_t        q[$];
    bit          m_ovf, m_err, m_ev;
    logic [63:0] m_exp;
    int          n_chk = 0;
    int          n_pass = 0;
    logic [63:0] nxt;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic step(input logic [1:0] v, input logic [63:0] o0, input logic [63:0] o1,
                        input logic rdy);
        logic [255:0] r [2];
        logic [63:0]  o [2];
        bit           pop;
        int           n;
        for (int l = 0; l < 2; l++)
            for (int i = 0; i < 8; i++) r[l][i*32 +: 32] = $urandom;
        o[0] = o0;
        o[1] = o1;
        bus.in_valid_i  = v;
        bus.in_order_i  = {o1, o0};
        bus.in_rec_i    = {r[1], r[0]};
        bus.out_ready_i = rdy;
        check("out_valid", bus.out_valid_o, q.size() != 0);
        if (q.size() != 0) begin
            check("out_order", bus.out_order_o, q[0].o);
            check("out_rec", bus.out_rec_o, q[0].r);
        end
        n   = int'(v[0]) + int'(v[1]);
        pop = (q.size() != 0) && rdy;
        @(posedge clk);
        #1;
        if (pop) void'(q.pop_front());
        if (q.size() + n <= DEPTH) begin
            for (int l = 0; l < 2; l++) begin
                if (v[l]) begin
                    if (m_ev && o[l] != m_exp) m_err = 1'b1;
                    m_exp = o[l] + 64'd1;
                    m_ev  = 1'b1;
                    q.push_back('{o: o[l], r: r[l]});
                end
            end
        end else begin
            m_ovf = 1'b1;
        end
        check("count", count, q.size());
        check("overflow", ovf, m_ovf);
        check("order_err", err, m_err);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.in_valid_i  = 2'b11;
        bus.in_order_i  = {64'd77, 64'd99};
        bus.in_rec_i    = '1;
        bus.out_ready_i = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        m_ovf = 0;
        m_err = 0;
        m_ev  = 0;
        m_exp = '0;
        check("rst_count", count, 0);
        check("rst_valid", bus.out_valid_o, 0);
        check("rst_order", bus.out_order_o, 0);
        check("rst_rec", bus.out_rec_o, 0);
        check("rst_ovf", ovf, 0);
        check("rst_err", err, 0);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && q.size() != 0; i++)
            step(2'b00, 64'd0, 64'd0, 1'b1);
        check("drained", count, 0);
    endtask

    task automatic rand_run(input int cycles, input bit gaps, input int rdy_pct);
        logic [1:0]  v;
        logic [63:0] o [2];
        for (int c = 0; c < cycles; c++) begin
            v = 2'($urandom_range(0, 3));
            o[0] = 64'd0;
            o[1] = 64'd0;
            for (int l = 0; l < 2; l++) begin
                if (v[l]) begin
                    if (gaps && $urandom_range(0, 15) == 0) nxt = nxt + 64'd3;
                    o[l] = nxt;
                    nxt  = nxt + 64'd1;
                end
            end
            step(v, o[0], o[1], $urandom_range(0, 99) < rdy_pct);
        end
    endtask

    initial begin
        bus.out_ready_i = 1'b0;
        bus.in_valid_i  = '0;
        bus.in_order_i  = '0;
        bus.in_rec_i    = '0;
        rst = 1'b1;
        @(posedge clk);
        do_reset();

        for (int i = 1; i <= 5; i++)
            step(2'b01, 64'(i), 64'd0, 1'b1);
        drain();

        do_reset();
        step(2'b11, 64'd10, 64'd11, 1'b0);
        step(2'b11, 64'd12, 64'd13, 1'b0);
        drain();

        do_reset();
        step(2'b10, 64'd0, 64'd7, 1'b1);
        step(2'b01, 64'd8, 64'd0, 1'b1);
        drain();

        do_reset();
        for (int i = 0; i < 4; i++)
            step(2'b11, 64'(2*i), 64'(2*i+1), 1'b0);
        step(2'b11, 64'd8, 64'd9, 1'b0);
        step(2'b01, 64'd8, 64'd0, 1'b1);
        drain();

        do_reset();
        step(2'b01, 64'd1, 64'd0, 1'b1);
        step(2'b01, 64'd2, 64'd0, 1'b1);
        step(2'b01, 64'd4, 64'd0, 1'b1);
        step(2'b01, 64'd5, 64'd0, 1'b1);
        drain();

        do_reset();
        nxt = 64'd100;
        rand_run(30, 1'b0, 80);
        drain();
        step(2'b11, 64'd200, 64'd201, 1'b0);
        step(2'b11, 64'd202, 64'd203, 1'b0);
        step(2'b01, 64'd204, 64'd0, 1'b0);
        do_reset();

        nxt = 64'hFFFF_FFFF_FFFF_FF00;
        rand_run(400, 1'b1, 45);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
